// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one instruction-memory request at a time,
// holds the fetched word for execute and computes the next PC on acknowledge.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ack,
  input  logic        PCSrc,
  input  logic        JALR_Src,
  input  logic [31:0] ImmExt,
  input  logic [31:0] ALUResult,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7_5,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        fetch_err
);

  localparam int unsigned CNT_W = 8;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               req_q, req_d;
  logic               valid_q, valid_d;
  logic [31:0]        pc_plus4;
  logic [31:0]        next_pc;
  logic               unused_alu_lsb;

  // JALR targets always drop bit 0 of the computed address
  assign unused_alu_lsb = ALUResult[0];

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    if (!PCSrc) begin
      next_pc = pc_plus4;
    end else if (!JALR_Src) begin
      next_pc = pc_q + ImmExt;
    end else begin
      next_pc = {ALUResult[31:1], 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          cnt_d   = '0;
          state_d = HOLD;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (instr_ack) begin
          // a target with bit 1 set cannot be fetched; stop with PC intact
          if (next_pc[1]) begin
            err_d   = 1'b1;
            state_d = HALT;
          end else begin
            pc_d    = next_pc;
            state_d = REQ;
          end
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
    req_d   = (state_d == REQ);
    valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign op          = instr_q[6:0];
  assign funct3      = instr_q[14:12];
  assign funct7_5    = instr_q[30];
  assign PC          = pc_q;
  assign PCPlus4     = pc_plus4;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed spec scenarios plus randomized
// fetch/ack traffic compared against a transaction-level PC model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ack;
  logic        PCSrc;
  logic        JALR_Src;
  logic [31:0] ImmExt;
  logic [31:0] ALUResult;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        fetch_err;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] model_pc;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ack(instr_ack),
    .PCSrc(PCSrc), .JALR_Src(JALR_Src), .ImmExt(ImmExt), .ALUResult(ALUResult),
    .instr(instr), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .PC(PC), .PCPlus4(PCPlus4), .fetch_err(fetch_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic scramble_ctrl();
    PCSrc     = 1'($urandom);
    JALR_Src  = 1'($urandom);
    ImmExt    = $urandom;
    ALUResult = $urandom;
  endtask

  // Asserts reset at a falling edge, checks the immediate reset values, releases it.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", PC, RESET_PC);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_op", 32'(op), 32'h13);
    check("rst_err", 32'(fetch_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_pc = RESET_PC;
    @(negedge clk);
    check("rel_req", 32'(imem_req), 32'd1);
    check("rel_addr", imem_addr, RESET_PC);
  endtask

  // One instruction: rvalid after dly extra REQ cycles, then ack with the given controls.
  task automatic fetch_one(input int dly, input logic src, input logic jalr,
                           input logic [31:0] imm, input logic [31:0] alu,
                           output logic halted);
    logic [31:0] data;
    logic [31:0] tgt;
    int          h;
    halted = 1'b0;
    data   = $urandom;
    check("req", 32'(imem_req), 32'd1);
    check("addr", imem_addr, model_pc);
    check("pc", PC, model_pc);
    check("pc4", PCPlus4, model_pc + 32'd4);
    check("err_pre", 32'(fetch_err), 32'd0);
    repeat (dly) begin
      instr_ack = 1'($urandom);
      scramble_ctrl();
      @(negedge clk);
      check("req_wait", 32'(imem_req), 32'd1);
      check("addr_wait", imem_addr, model_pc);
    end
    instr_ack   = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    check("valid", 32'(instr_valid), 32'd1);
    check("req_hold", 32'(imem_req), 32'd0);
    check("instr", instr, data);
    check("op", 32'(op), 32'(data[6:0]));
    check("funct3", 32'(funct3), 32'(data[14:12]));
    check("funct7_5", 32'(funct7_5), 32'(data[30]));
    h = int'($urandom_range(0, 2));
    repeat (h) begin
      imem_rvalid = 1'b1;
      imem_rdata  = ~data;
      scramble_ctrl();
      @(negedge clk);
      imem_rvalid = 1'b0;
      check("instr_stable", instr, data);
      check("valid_stable", 32'(instr_valid), 32'd1);
    end
    instr_ack = 1'b1;
    PCSrc     = src;
    JALR_Src  = jalr;
    ImmExt    = imm;
    ALUResult = alu;
    if (!src)       tgt = model_pc + 32'd4;
    else if (!jalr) tgt = model_pc + imm;
    else            tgt = alu & 32'hFFFF_FFFE;
    @(negedge clk);
    instr_ack = 1'b0;
    scramble_ctrl();
    if (tgt[1]) begin
      halted = 1'b1;
      check("mis_err", 32'(fetch_err), 32'd1);
      check("mis_req", 32'(imem_req), 32'd0);
      check("mis_valid", 32'(instr_valid), 32'd0);
      check("mis_pc", PC, model_pc);
      check("mis_instr", instr, data);
    end else begin
      model_pc = tgt;
      check("err_post", 32'(fetch_err), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        halted;
    logic [31:0] frozen_pc;
    rst = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0; instr_ack = 1'b0;
    PCSrc = 1'b0; JALR_Src = 1'b0; ImmExt = '0; ALUResult = '0;
    model_pc = RESET_PC;
    repeat (2) @(negedge clk);
    do_reset();

    // sequential 0x0, 0x4, 0x8; branch back from 0x8; JALR to 0x100
    fetch_one(0, 1'b0, 1'b0, 32'd0, 32'd0, halted);
    fetch_one(0, 1'b0, 1'b0, 32'd0, 32'd0, halted);
    check("seq_pc8", model_pc, 32'h8);
    fetch_one(0, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'd0, halted);
    check("br_addr", imem_addr, 32'h0);
    fetch_one(1, 1'b1, 1'b1, 32'd0, 32'h101, halted);
    check("jalr_addr", imem_addr, 32'h100);

    for (int i = 0; i < 40; i++) begin
      fetch_one(int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFD, halted);
    end

    // misaligned JALR target halts with PC frozen
    frozen_pc = model_pc;
    fetch_one(0, 1'b1, 1'b1, 32'd0, 32'h106, halted);
    check("mis_halted", 32'(halted), 32'd1);
    for (int i = 0; i < 5; i++) begin
      imem_rvalid = 1'b1; imem_rdata = $urandom; instr_ack = 1'b1; scramble_ctrl();
      @(negedge clk);
      check("halt_req", 32'(imem_req), 32'd0);
      check("halt_valid", 32'(instr_valid), 32'd0);
      check("halt_pc", PC, frozen_pc);
      check("halt_err", 32'(fetch_err), 32'd1);
    end
    imem_rvalid = 1'b0; instr_ack = 1'b0;

    // timeout: 16 REQ cycles without rvalid
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      check("to_req", 32'(imem_req), 32'd1);
      check("to_err_low", 32'(fetch_err), 32'd0);
      @(negedge clk);
    end
    check("to_err", 32'(fetch_err), 32'd1);
    check("to_req_off", 32'(imem_req), 32'd0);
    check("to_instr", instr, 32'h0000_0013);

    // rvalid on the 16th REQ cycle is still accepted
    do_reset();
    fetch_one(15, 1'b0, 1'b0, 32'd0, 32'd0, halted);
    check("to16_ok", 32'(fetch_err), 32'd0);
    check("to16_addr", imem_addr, 32'h4);

    // reset while requesting
    @(negedge clk);
    check("mid_req_before", 32'(imem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_req", 32'(imem_req), 32'd0);
    check("mid_pc", PC, RESET_PC);
    check("mid_err", 32'(fetch_err), 32'd0);
    do_reset();
    fetch_one(0, 1'b0, 1'b0, 32'd0, 32'd0, halted);
    check("refetch_addr", imem_addr, RESET_PC + 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
